demux_dispatch_ctrl: RTL and testbench

Controller that sequences the 1-to-4 demultiplexer datapath. It accepts a data stream on one valid/ready input and dispatches each word to exactly one of four output channels. The channel is chosen by round-robin or by a per-word destination field. A one-entry holding register decouples the input from the output channels and drives the demux select, so the downstream consumers see a registered, handshake-safe interface.

---
 rtl/demux_dispatch_if.sv | 23 ++
 rtl/demux_dispatch_ctrl.sv | 93 +++++++++
 tb/tb_demux_dispatch_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_dispatch_if.sv
// Valid/ready bundle for the 1-to-4 dispatch controller: one input stream,
// four one-hot output channels sharing a single data bus.
interface demux_dispatch_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// One-entry holding register that dispatches each input word to one of four
// channels, chosen round-robin or by the per-word destination field.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_EMPTY | nothing held; input always accepted (once out of reset)
// S_FULL  | word held for channel sel; waits for that channel only
module demux_dispatch_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  demux_dispatch_if.slave   bus,
  output logic [1:0]        sel,
  output logic [1:0]        rr_ptr,
  output logic [CNT_W-1:0]  dispatch_cnt
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_en_q;

  logic [3:0] out_valid_oh;
  logic       in_rdy;
  logic       xfer;
  logic       capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      data_q   <= '0;
      sel_q    <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    out_valid_oh = 4'b0000;
    state_d      = state_q;
    data_d       = data_q;
    sel_d        = sel_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;

    if (state_q == S_FULL)
      out_valid_oh = 4'b0001 << sel_q;

    xfer    = |(out_valid_oh & bus.out_ready);
    // Pass-through ready lets a new word land in the same cycle the held one leaves.
    in_rdy  = rdy_en_q & ((state_q == S_EMPTY) | bus.out_ready[sel_q]);
    capture = bus.in_valid & in_rdy;

    if (capture) begin
      state_d = S_FULL;
      data_d  = bus.in_data;
      if (mode) begin
        sel_d = bus.in_dest;
      end else begin
        sel_d = rr_q;
        rr_d  = rr_q + 2'd1;
      end
    end else if (xfer) begin
      state_d = S_EMPTY;
    end

    if (xfer)
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_oh;
  assign bus.out_data  = data_q;
  assign sel           = sel_q;
  assign rr_ptr        = rr_q;
  assign dispatch_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl (counter narrowed to 4 bits so the
// wrap case is reachable quickly).
module tb_demux_dispatch_ctrl;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic [1:0]       sel;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] dispatch_cnt;

  int n_cmp;
  int n_bad;

  demux_dispatch_if #(.DATA_W(DATA_W)) bif ();

  demux_dispatch_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .bus          (bif.slave),
    .sel          (sel),
    .rr_ptr       (rr_ptr),
    .dispatch_cnt (dispatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] dests [5];
  logic [3:0] oh;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    dests[0] = 2'd2; dests[1] = 2'd0; dests[2] = 2'd3; dests[3] = 2'd3; dests[4] = 2'd1;

    rst_n         = 1'b0;
    mode          = 1'b0;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.in_dest   = '0;
    bif.out_ready = 4'b1111;

    // reset state
    #12;
    chk("rst_out_valid", bif.out_valid, 4'b0000);
    chk("rst_in_ready", bif.in_ready, 1'b0);
    chk("rst_out_data", bif.out_data, 8'h00);
    chk("rst_sel", sel, 2'd0);
    chk("rst_rr", rr_ptr, 2'd0);
    chk("rst_cnt", dispatch_cnt, 4'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", bif.in_ready, 1'b1);

    // 1: round-robin, all ready
    for (int i = 0; i < 8; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = 8'hA0 + 8'(i);
      step();
      oh = 4'b0001 << (i % 4);
      chk("t1_out_valid", bif.out_valid, oh);
      chk("t1_out_data", bif.out_data, 8'hA0 + 8'(i));
      chk("t1_in_ready", bif.in_ready, 1'b1);
    end
    bif.in_valid = 1'b0;
    step();
    chk("t1_drain_valid", bif.out_valid, 4'b0000);
    chk("t1_cnt", dispatch_cnt, 4'd8);
    chk("t1_rr", rr_ptr, 2'd0);

    // 2: directed
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = 8'h11 + 8'(i);
      bif.in_dest  = dests[i];
      step();
      oh = 4'b0001 << dests[i];
      chk("t2_out_valid", bif.out_valid, oh);
      chk("t2_out_data", bif.out_data, 8'h11 + 8'(i));
      chk("t2_sel", sel, dests[i]);
    end
    bif.in_valid = 1'b0;
    step();
    chk("t2_rr", rr_ptr, 2'd0);
    chk("t2_cnt", dispatch_cnt, 4'd13);

    // 3: backpressure on ch1
    mode = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h50;
    step();
    chk("t3_fill_valid", bif.out_valid, 4'b0001);
    bif.in_data = 8'h5A;
    step();
    chk("t3_5a_valid", bif.out_valid, 4'b0010);
    bif.out_ready = 4'b1101;
    bif.in_data   = 8'h5B;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", bif.out_valid, 4'b0010);
      chk("t3_hold_data", bif.out_data, 8'h5A);
      chk("t3_hold_in_ready", bif.in_ready, 1'b0);
      chk("t3_hold_cnt", dispatch_cnt, 4'd14);
    end
    bif.out_ready = 4'b1111;
    #1;
    chk("t3_release_in_ready", bif.in_ready, 1'b1);
    step();
    chk("t3_xfer_cnt", dispatch_cnt, 4'd15);
    chk("t3_new_valid", bif.out_valid, 4'b0100);
    chk("t3_new_data", bif.out_data, 8'h5B);
    bif.in_data = 8'h5C;
    step();
    chk("t3_wrap_cnt", dispatch_cnt, 4'd0);
    chk("t3_5c_valid", bif.out_valid, 4'b1000);
    bif.in_valid = 1'b0;
    step();
    chk("t3_rr", rr_ptr, 2'd0);
    chk("t3_cnt_end", dispatch_cnt, 4'd1);

    // 4: mode switch while FULL
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h33;
    step();
    chk("t4_sel", sel, 2'd0);
    bif.out_ready = 4'b0000;
    mode          = 1'b1;
    bif.in_dest   = 2'd3;
    bif.in_data   = 8'h44;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_hold_valid", bif.out_valid, 4'b0001);
      chk("t4_hold_data", bif.out_data, 8'h33);
      chk("t4_hold_in_ready", bif.in_ready, 1'b0);
    end
    bif.out_ready = 4'b1111;
    step();
    chk("t4_cnt", dispatch_cnt, 4'd2);
    chk("t4_next_valid", bif.out_valid, 4'b1000);
    chk("t4_next_data", bif.out_data, 8'h44);
    chk("t4_rr", rr_ptr, 2'd1);
    bif.in_valid = 1'b0;
    step();
    chk("t4_cnt_end", dispatch_cnt, 4'd3);

    // 5: reset while FULL
    mode          = 1'b0;
    bif.out_ready = 4'b0000;
    bif.in_valid  = 1'b1;
    bif.in_data   = 8'h77;
    step();
    chk("t5_pending_valid", bif.out_valid, 4'b0010);
    bif.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", bif.out_valid, 4'b0000);
    chk("t5_async_cnt", dispatch_cnt, 4'd0);
    chk("t5_async_data", bif.out_data, 8'h00);
    chk("t5_async_rr", rr_ptr, 2'd0);
    chk("t5_async_in_ready", bif.in_ready, 1'b0);
    bif.out_ready = 4'b1111;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_ghost_valid", bif.out_valid, 4'b0000);
      chk("t5_no_ghost_cnt", dispatch_cnt, 4'd0);
    end
    bif.in_valid = 1'b1;
    bif.in_data  = 8'h88;
    step();
    chk("t5_first_valid", bif.out_valid, 4'b0001);
    chk("t5_first_data", bif.out_data, 8'h88);
    bif.in_valid = 1'b0;
    step();
    chk("t5_first_cnt", dispatch_cnt, 4'd1);

    // 6: counter wrap after 17 transfers from reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = 8'(i);
      step();
    end
    bif.in_valid = 1'b0;
    step();
    chk("t6_valid_idle", bif.out_valid, 4'b0000);
    chk("t6_cnt_wrap", dispatch_cnt, 4'd1);
    chk("t6_rr", rr_ptr, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // One-hot guard on every cycle the bench is running.
  always @(negedge clk) begin
    if (rst_n && ($countones(bif.out_valid) > 1)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL onehot: got %b expected at most one bit", bif.out_valid);
    end
  end

endmodule
